// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM states and
// BCD digit geometry used by the snapshot muxes.
package alarm_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  // Comparison walks from the most significant digit (H1) downward
  localparam digit_idx_t DIGIT_LAST = digit_idx_t'(NUM_DIGITS - 1);

endpackage

// File: rtl/comparator.sv
// 4-bit equality comparator shared across the team's control blocks.
// Purely combinational; no special handling of any code point.
module comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: digit-serial time compare on one shared comparator,
// then ring / snooze timing driven by the external sec_tick.
//
//   state  | meaning
//   IDLE   | waiting for min_tick with alarm armed
//   CMP    | comparing one snapshot digit per cycle, H1 first
//   RING   | alarm sounding, counting ring seconds
//   SNOOZE | silenced, counting snooze seconds before re-ringing
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alarm_en,
  input  logic        min_tick,
  input  logic        sec_tick,
  input  logic [15:0] cur_time,
  input  logic [15:0] alarm_time,
  input  logic        stop,
  input  logic        snooze,
  output logic        ring,
  output logic        match,
  output logic        busy
);

  localparam int MAX_SEC = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int CNT_W   = (MAX_SEC < 2) ? 1 : $clog2(MAX_SEC + 1);
  localparam int SNZ_W   = (MAX_SNOOZE < 2) ? 1 : $clog2(MAX_SNOOZE + 1);

  state_t            state, state_nxt;
  logic [15:0]       snap_cur, snap_alarm;
  digit_idx_t        idx;
  logic [CNT_W-1:0]  sec_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic              match_q;

  logic [BCD_W-1:0]  dig_cur, dig_alarm;
  logic              dig_eq;

  logic do_snap, idx_dec, match_set;
  logic cnt_clr, cnt_inc, snz_clr, snz_inc;
  logic ring_done, snooze_done;

  assign dig_cur   = snap_cur[{idx, 2'b00} +: BCD_W];
  assign dig_alarm = snap_alarm[{idx, 2'b00} +: BCD_W];

  comparator u_cmp (
    .a  (dig_cur),
    .b  (dig_alarm),
    .eq (dig_eq)
  );

  // Timeout fires on the sec_tick that would bring the count to the limit
  assign ring_done   = sec_tick && (int'(sec_cnt) >= RING_SECONDS - 1);
  assign snooze_done = sec_tick && (int'(sec_cnt) >= SNOOZE_SECONDS - 1);

  always_comb begin
    state_nxt = state;
    do_snap   = 1'b0;
    idx_dec   = 1'b0;
    match_set = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    snz_clr   = 1'b0;
    snz_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (alarm_en && min_tick) begin
          do_snap   = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (!alarm_en || !dig_eq) begin
          state_nxt = IDLE;
        end else if (idx == '0) begin
          state_nxt = RING;
          match_set = 1'b1;
          cnt_clr   = 1'b1;
          snz_clr   = 1'b1;
        end else begin
          idx_dec = 1'b1;
        end
      end
      RING: begin
        if (!alarm_en || stop || ring_done) begin
          state_nxt = IDLE;
        end else if (snooze) begin
          if (int'(snz_cnt) < MAX_SNOOZE) begin
            state_nxt = SNOOZE;
            snz_inc   = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (sec_tick) begin
          cnt_inc = 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_en || stop) begin
          state_nxt = IDLE;
        end else if (snooze_done) begin
          state_nxt = RING;
          cnt_clr   = 1'b1;
        end else if (sec_tick) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap_cur   <= '0;
      snap_alarm <= '0;
      idx        <= DIGIT_LAST;
      sec_cnt    <= '0;
      snz_cnt    <= '0;
      match_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      match_q <= match_set;
      if (do_snap) begin
        snap_cur   <= cur_time;
        snap_alarm <= alarm_time;
        idx        <= DIGIT_LAST;
      end else if (idx_dec) begin
        idx <= idx - 1'b1;
      end
      // Saturating so the count can never wrap back below a limit
      if (cnt_clr) begin
        sec_cnt <= '0;
      end else if (cnt_inc && (sec_cnt != '1)) begin
        sec_cnt <= sec_cnt + 1'b1;
      end
      if (snz_clr) begin
        snz_cnt <= '0;
      end else if (snz_inc) begin
        snz_cnt <= snz_cnt + 1'b1;
      end
    end
  end

  assign ring  = (state == RING);
  assign busy  = (state != IDLE);
  assign match = match_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with short ring/snooze limits so
// timeout and snooze-limit behaviour is reachable in a few cycles.
module tb_alarm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        alarm_en;
  logic        min_tick;
  logic        sec_tick;
  logic [15:0] cur_time;
  logic [15:0] alarm_time;
  logic        stop;
  logic        snooze;
  logic        ring;
  logic        match;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alarm_controller #(
    .RING_SECONDS   (3),
    .SNOOZE_SECONDS (2),
    .MAX_SNOOZE     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_en   (alarm_en),
    .min_tick   (min_tick),
    .sec_tick   (sec_tick),
    .cur_time   (cur_time),
    .alarm_time (alarm_time),
    .stop       (stop),
    .snooze     (snooze),
    .ring       (ring),
    .match      (match),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs set afterwards apply at the following edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Launch a compare (edge k) and run through edge k+4
  task automatic bring_to_ring(input logic [15:0] t);
    cur_time   = t;
    alarm_time = t;
    min_tick   = 1'b1;
    cyc();
    min_tick   = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_en = 1'b1; min_tick = 1'b0; sec_tick = 1'b0;
    cur_time = 16'h0000; alarm_time = 16'h0000; stop = 1'b0; snooze = 1'b0;
    repeat (2) cyc();
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL reset_ring got=%b exp=0", ring); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", match); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_full_match();
    alarm_time = 16'h0730; cur_time = 16'h0730; min_tick = 1'b1;
    cyc();
    min_tick = 1'b0;
    for (int e = 0; e < 4; e++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL fm_busy edge=k+%0d got=%b exp=1", e, busy); end
      total++; if (ring !== 1'b0 || match !== 1'b0) begin bad++; $display("FAIL fm_early edge=k+%0d ring=%b match=%b exp=0,0", e, ring, match); end
      cyc();
    end
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL fm_ring got=%b exp=1", ring); end
    total++; if (match !== 1'b1) begin bad++; $display("FAIL fm_match got=%b exp=1", match); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fm_busy_ring got=%b exp=1", busy); end
    cyc();
    total++; if (match !== 1'b0 || ring !== 1'b1) begin bad++; $display("FAIL fm_pulse match=%b ring=%b exp=0,1", match, ring); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++; if (ring !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop ring=%b busy=%b exp=0,0", ring, busy); end
    cyc();
  endtask

  task automatic test_early_exit();
    alarm_time = 16'h0730; cur_time = 16'h1730; min_tick = 1'b1;
    cyc();
    min_tick = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ee_h1_busy_k got=%b exp=1", busy); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ee_h1_idle got=%b exp=0", busy); end
    repeat (4) begin
      cyc();
      total++; if (ring !== 1'b0 || match !== 1'b0) begin bad++; $display("FAIL ee_h1_quiet ring=%b match=%b exp=0,0", ring, match); end
    end
    cur_time = 16'h0731; min_tick = 1'b1;
    cyc();
    min_tick = 1'b0;
    repeat (3) cyc();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ee_m0_busy_k3 got=%b exp=1", busy); end
    cyc();
    total++; if (busy !== 1'b0 || match !== 1'b0 || ring !== 1'b0) begin bad++; $display("FAIL ee_m0_idle busy=%b match=%b ring=%b exp=0,0,0", busy, match, ring); end
    cyc();
  endtask

  task automatic test_timeout();
    bring_to_ring(16'h2359);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL to_ring got=%b exp=1", ring); end
    for (int s = 1; s <= 3; s++) begin
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
      total++; if (ring !== (s < 3)) begin bad++; $display("FAIL to_tick%0d ring=%b exp=%b", s, ring, (s < 3)); end
      cyc();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_snooze_limit();
    bring_to_ring(16'h0600);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    total++; if (ring !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL sn_enter ring=%b busy=%b exp=0,1", ring, busy); end
    sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL sn_tick1 ring=%b exp=0", ring); end
    cyc();
    sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL sn_rering ring=%b exp=1", ring); end
    cyc();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    total++; if (busy !== 1'b0 || ring !== 1'b0) begin bad++; $display("FAIL sn_limit busy=%b ring=%b exp=0,0", busy, ring); end
    cyc();
    bring_to_ring(16'h0601);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL sn_ring2 got=%b exp=1", ring); end
    stop = 1'b1; snooze = 1'b1;
    cyc();
    stop = 1'b0; snooze = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sn_stop_prio busy=%b exp=0", busy); end
    cyc();
  endtask

  task automatic test_disruption();
    alarm_time = 16'h0730; cur_time = 16'h0730; min_tick = 1'b1;
    cyc();
    cur_time = 16'h1111;
    repeat (4) cyc();
    min_tick = 1'b0;
    total++; if (ring !== 1'b1 || match !== 1'b1) begin bad++; $display("FAIL dis_snapshot ring=%b match=%b exp=1,1", ring, match); end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (ring !== 1'b0 || match !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dis_rst ring=%b match=%b busy=%b exp=0,0,0", ring, match, busy); end
    cyc();
    bring_to_ring(16'h1245);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    total++; if (busy !== 1'b1 || ring !== 1'b0) begin bad++; $display("FAIL dis_snz busy=%b ring=%b exp=1,0", busy, ring); end
    alarm_en = 1'b0;
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_en busy=%b exp=0", busy); end
    min_tick = 1'b1;
    cyc();
    min_tick = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_disarmed busy=%b exp=0", busy); end
    alarm_en = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_full_match();
    test_early_exit();
    test_timeout();
    test_snooze_limit();
    test_disruption();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
